// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end with a small prefetch FIFO.
// Runs the fetch PC and issues one-word requests to a synchronous instruction
// memory. It buffers each returned word together with its PC and presents the
// oldest entry to IF/ID. A stall holds the head; a taken branch flushes the
// queue and re-targets the fetch PC.

// Run-time guards for the queue bookkeeping.
module if_prefetch_queue_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          enq,
  input logic [CW-1:0] count
);

  // The credit rule must never let a response arrive into a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(enq && (count == CW'(DEPTH))));

  // The occupancy counter never exceeds the physical depth.
  a_count_range: assert property (@(posedge clk) disable iff (reset)
    (count <= CW'(DEPTH)));

endmodule

module if_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PCSrc,
  input  logic [31:0]              PC_Branch,
  input  logic                     IF_ID_write,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              PC_IF,
  output logic [31:0]              INSTRUCTION_IF,
  output logic                     fetch_valid,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  // One extra bit so count + inflight cannot wrap.
  localparam int unsigned CRW = CW + 1;
  localparam logic [CRW-1:0] DEPTH_C = CRW'(DEPTH);

  logic [31:0]    fetch_pc_r;
  logic           inflight_r;
  logic [31:0]    inflight_pc_r;
  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [CW-1:0]  count_r;
  logic [31:0]    instr_mem_r [DEPTH];
  logic [31:0]    pc_mem_r    [DEPTH];

  logic [CRW-1:0] credit_s;
  logic           imem_req_s;
  logic           enq_s;
  logic           deq_s;
  logic           fetch_valid_s;

  // Request credit and the enqueue/dequeue strobes.
  // A dequeue in the same cycle does not free a credit, which keeps the
  // request decision independent of IF_ID_write.
  always_comb begin
    credit_s      = CRW'(count_r) + CRW'(inflight_r);
    fetch_valid_s = (count_r != CW'(0));
    if (reset) begin
      imem_req_s = 1'b0;
    end else begin
      imem_req_s = !PCSrc && (credit_s < DEPTH_C);
    end
    enq_s = inflight_r && !PCSrc;
    deq_s = fetch_valid_s && IF_ID_write && !PCSrc;
  end

  // Fetch PC and the single outstanding memory request.
  // A redirect drops any in-flight response by clearing inflight_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= RESET_PC;
    end else if (PCSrc) begin
      fetch_pc_r    <= PC_Branch;
      inflight_r    <= 1'b0;
    end else if (imem_req_s) begin
      fetch_pc_r    <= fetch_pc_r + 32'd4;
      inflight_r    <= 1'b1;
      inflight_pc_r <= fetch_pc_r;
    end else begin
      inflight_r    <= 1'b0;
    end
  end

  // Queue pointers and occupancy. A redirect empties the queue and overrides
  // any dequeue in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= PW'(0);
      tail_r  <= PW'(0);
      count_r <= CW'(0);
    end else if (PCSrc) begin
      head_r  <= PW'(0);
      tail_r  <= PW'(0);
      count_r <= CW'(0);
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (deq_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage. Entries are only read while valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      instr_mem_r[tail_r] <= imem_rdata;
      pc_mem_r[tail_r]    <= inflight_pc_r;
    end
  end

  // Head presentation. The outputs come straight from queue registers and are
  // masked to PC 0 and a NOP when the queue is empty.
  always_comb begin
    PC_IF          = 32'h0000_0000;
    INSTRUCTION_IF = NOP_INSTR;
    if (fetch_valid_s) begin
      PC_IF          = pc_mem_r[head_r];
      INSTRUCTION_IF = instr_mem_r[head_r];
    end else begin
      PC_IF          = 32'h0000_0000;
      INSTRUCTION_IF = NOP_INSTR;
    end
    fetch_valid = fetch_valid_s;
    queue_count = count_r;
    imem_req    = imem_req_s;
    imem_addr   = fetch_pc_r;
  end

  if_prefetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .enq   (enq_s),
    .count (count_r)
  );

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Instruction-fetch front end with a small prefetch FIFO. It sits directly upstream of the IF/ID pipeline register and replaces the bare PC-plus-memory fetch path. It runs the fetch PC, issues one-word requests to a synchronous instruction memory, and buffers returned instructions with their PCs. It presents the oldest buffered instruction to IF/ID, honours the hazard unit's `IF_ID_write` stall, and flushes on a taken branch (`PCSrc`/`PC_Branch`).

## Interface
- `DEPTH`, 4 — FIFO entries (power of two, ≥2)
- `RESET_PC`, 32'h0000_0000 — fetch PC after reset
- `NOP_INSTR`, 32'h0000_0013 — instruction driven when the FIFO is empty (addi x0,x0,0)

Ports:
- `clk`  in  1  — single clock, all state updates on its rising edge
- `reset`  in  1  — asynchronous, active-high; clears all state immediately
- `PCSrc`  in  1  — branch taken in EX; redirect fetch to `PC_Branch`
- `PC_Branch`  in  32  — redirect target
- `IF_ID_write`  in  1  — consumer accepts head entry this cycle (0 = stall)
- `imem_req`  out  1  — read request to instruction memory
- `imem_addr`  out  32  — word address (byte PC) of request
- `imem_rdata`  in  32  — read data, valid the cycle after `imem_req`
- `PC_IF`  out  32  — PC of head entry; 0 when empty
- `INSTRUCTION_IF`  out  32  — head instruction; `NOP_INSTR` when empty
- `fetch_valid`  out  1  — FIFO non-empty
- `queue_count`  out  clog2(DEPTH)+1  — entries currently buffered

## Operation
- State: `fetch_pc`, FIFO (instr and PC per entry, head/tail pointers, count), `inflight` flag, `inflight_pc`.
- Request rule: `imem_req = !PCSrc && (count + inflight < DEPTH)`.
  - Conservative rule: a same-cycle dequeue does not free a credit.
  - `imem_addr = fetch_pc` always.
- On an edge with `imem_req=1`: `fetch_pc <= fetch_pc + 4` (mod 2^32, 0xFFFF_FFFC wraps to 0); `inflight <= 1`; `inflight_pc <= fetch_pc`. Otherwise `inflight <= 0`.
- Enqueue: on an edge where `inflight=1` and `PCSrc=0`, write `{imem_rdata, inflight_pc}` at tail.
  - The credit rule guarantees no overflow; an enqueue into a full FIFO is an assertion failure.
- Dequeue: on an edge where `fetch_valid && IF_ID_write`, advance head.
  - `IF_ID_write` while empty has no effect.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Redirect (`PCSrc=1`), which takes priority over everything except reset:
  - At the next edge, FIFO emptied (count 0, pointers equal).
  - Inflight response discarded, `inflight <= 0`.
  - `fetch_pc <= PC_Branch`.
  - No request is issued in the redirect cycle.
  - A dequeue in the same cycle is superseded; IF/ID is flushed by its own logic.
- `PCSrc` held high for several cycles: each cycle re-targets `fetch_pc` and keeps the FIFO empty.
- Reset (asserted at any time, including mid-fetch or mid-redirect):
  - `fetch_pc = RESET_PC`, FIFO empty, `inflight = 0`.
  - Outputs forced immediately: `fetch_valid=0`, `queue_count=0`, `PC_IF=0`, `INSTRUCTION_IF=NOP_INSTR`, `imem_req=0`, `imem_addr=RESET_PC`.

## Timing
- Head outputs are driven from FIFO registers; there is no combinational path from `imem_rdata` to `INSTRUCTION_IF`.
- Fetch latency: request at edge N → entry visible after edge N+1. The first instruction after reset release is valid 2 edges after the first edge with reset low.
- Redirect penalty: `PCSrc` at edge R → request for `PC_Branch` at edge R+1 → `fetch_valid` after edge R+2.
- Throughput with `IF_ID_write=1` continuously: one instruction per cycle sustained once count ≥1 (DEPTH ≥ 2).
- Stall: while `IF_ID_write=0`, head outputs are stable. The FIFO fills to DEPTH, then `imem_req` drops. Once the head is accepted, `imem_req` reasserts on the cycle after count + inflight < DEPTH.
- `imem_req` and `imem_addr` are combinational from registered state and `PCSrc` only.

## Test plan
- Reset release, memory word[i]=i, `IF_ID_write=1` → `imem_addr` 0,4,8,…; `fetch_valid` rises on 2nd edge; head sequence (PC 0, instr 0), (4, 1), (8, 2)… with no bubbles after the first.
- Hold `IF_ID_write=0` for 10 cycles → `queue_count` saturates at 4, `imem_req=0`, head stays at PC 0. Release → PCs 0,4,8,12,16 in order, no loss or duplication.
- `PCSrc=1`, `PC_Branch=0x100` with 3 entries queued and a request in flight → next cycle count 0, `fetch_valid=0`; then `imem_addr=0x100`; head PC 0x100 two edges after redirect. The stale inflight word is never enqueued.
- Redirect coinciding with a full FIFO and `IF_ID_write=1` → FIFO empty, no dequeue side effects, fetch resumes at target.
- `RESET_PC=0xFFFF_FFF8` → requests at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, with PCs carried correctly.
- Assert reset asynchronously mid-stream (between edges) → outputs go to reset values before the next edge; after release, fetch restarts at `RESET_PC`.
